// File: rtl/fwrisc_bus_arb.sv
// fwrisc_bus_arb: N-master to single-slave bus arbiter with a two-state
// IDLE/BUSY machine. A winner's request fields are captured on grant and
// replayed to the slave until s_ready completes the transaction.
// Optional build macro FWRISC_BUS_ARB_RR_EN selects round-robin arbitration;
// without it the lowest requesting index always wins and no pointer exists.
module fwrisc_bus_arb #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_MASTERS-1:0]                m_valid,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0] m_wstb,
  input  logic [N_MASTERS-1:0]                m_write,
  output logic [N_MASTERS-1:0]                m_ready,
  output logic [DATA_WIDTH-1:0]               m_rdata,
  output logic                                s_valid,
  output logic [ADDR_WIDTH-1:0]               s_addr,
  output logic [DATA_WIDTH-1:0]               s_wdata,
  output logic [(DATA_WIDTH/8)-1:0]           s_wstb,
  output logic                                s_write,
  input  logic [DATA_WIDTH-1:0]               s_rdata,
  input  logic                                s_ready,
  output logic [N_MASTERS-1:0]                grant
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [N_MASTERS-1:0]  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstb_q, wstb_d;
  logic                  write_q, write_d;

  logic [N_MASTERS-1:0]  win_oh_s;
  logic [IW-1:0]         win_idx_s;
  logic                  win_found_s;

`ifdef FWRISC_BUS_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Round-robin winner search starting one past the last winner
  always_comb begin
    logic [IW-1:0] cand_v;
    win_oh_s    = '0;
    win_idx_s   = '0;
    win_found_s = 1'b0;
    cand_v      = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand_v = IW'((int'(ptr_q) + 1 + k) % N_MASTERS);
      if (!win_found_s && m_valid[cand_v]) begin
        win_found_s      = 1'b1;
        win_idx_s        = cand_v;
        win_oh_s[cand_v] = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pointer follows the winner of every new grant
  always_comb begin
    if ((state_q == ST_IDLE) && win_found_s) begin
      ptr_d = win_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, reset so that master 0 is searched first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= IW'(N_MASTERS - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed-priority winner search: lowest requesting index wins
  always_comb begin
    logic [IW-1:0] cand_v;
    win_oh_s    = '0;
    win_idx_s   = '0;
    win_found_s = 1'b0;
    cand_v      = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand_v = IW'(k);
      if (!win_found_s && m_valid[cand_v]) begin
        win_found_s      = 1'b1;
        win_idx_s        = cand_v;
        win_oh_s[cand_v] = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end
`endif

  // Next-state logic: capture winner in IDLE, release on s_ready in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstb_d  = wstb_q;
    write_d = write_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_BUSY;
          grant_d = win_oh_s;
          addr_d  = m_addr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = m_wdata[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
          wstb_d  = m_wstb[win_idx_s*SW +: SW];
          write_d = m_write[win_idx_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Fields are cleared on completion so the slave side reads 0 when idle
        if (s_ready) begin
          state_d = ST_IDLE;
          grant_d = '0;
          addr_d  = '0;
          wdata_d = '0;
          wstb_d  = '0;
          write_d = 1'b0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        addr_d  = '0;
        wdata_d = '0;
        wstb_d  = '0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and captured request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstb_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstb_q  <= wstb_d;
      write_q <= write_d;
    end
  end

  // Slave side comes straight from registers; completion is combinational
  assign s_valid = (state_q == ST_BUSY);
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstb  = wstb_q;
  assign s_write = write_q;
  assign grant   = grant_q;
  assign m_ready = (s_valid && s_ready) ? grant_q : '0;
  assign m_rdata = (s_valid && s_ready) ? s_rdata : '0;

endmodule
